// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding
// and default frame parameters.
package uart_pkg;

    localparam int ST_W        = 3;
    localparam int DEF_N_BIT   = 8;
    localparam int DEF_N_TICK  = 16;
    localparam int DEF_SB_TICK = 16;

    typedef enum logic [ST_W-1:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Resets to 1 so an idle-high line looks idle out of reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserialiser: oversampled start/data/stop detection,
// LSB-first shift, one-cycle done / framing-error strobes.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int N_BIT   = DEF_N_BIT,
    parameter int N_TICK  = DEF_N_TICK,
    parameter int SB_TICK = DEF_SB_TICK
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             s_tick,
    input  logic             rx,
    output logic [N_BIT-1:0] dout,
    output logic             rx_done_tick,
    output logic             frame_err,
    output logic             busy
);

    localparam int S_MAX = (SB_TICK > N_TICK) ? SB_TICK : N_TICK;
    localparam int S_W   = $clog2(S_MAX);
    localparam int N_W   = (N_BIT > 1) ? $clog2(N_BIT) : 1;

    localparam logic [S_W-1:0] S_HALF = S_W'(N_TICK / 2 - 1);
    localparam logic [S_W-1:0] S_BIT  = S_W'(N_TICK - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [S_W-1:0] S_ONE  = S_W'(1);
    localparam logic [N_W-1:0] N_LAST = N_W'(N_BIT - 1);
    localparam logic [N_W-1:0] N_ONE  = N_W'(1);

    uart_state_t      state, state_n;
    logic [S_W-1:0]   s, s_n;
    logic [N_W-1:0]   n, n_n;
    logic [N_BIT-1:0] sh, sh_n;
    logic [N_BIT-1:0] dout_n;
    logic             done_n, err_n;
    logic             rx_s;

    sync_2ff u_sync (
        .clk   (CLK),
        .rst_n (RESET),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            sh           <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_n;
            s            <= s_n;
            n            <= n_n;
            sh           <= sh_n;
            dout         <= dout_n;
            rx_done_tick <= done_n;
            frame_err    <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        sh_n    = sh;
        dout_n  = dout;
        done_n  = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    s_n     = '0;
                end
            end
            START: begin
                // a start bit must still be low at its midpoint
                if (s_tick) begin
                    if (s == S_HALF) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            s_n     = '0;
                            n_n     = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_n = s + S_ONE;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == S_BIT) begin
                        s_n  = '0;
                        sh_n = {rx_s, sh[N_BIT-1:1]};
                        if (n == N_LAST) begin
                            state_n = STOP;
                        end else begin
                            n_n = n + N_ONE;
                        end
                    end else begin
                        s_n = s + S_ONE;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == S_STOP) begin
                        if (rx_s) begin
                            dout_n  = sh;
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            err_n   = 1'b1;
                            state_n = BREAK;
                        end
                    end else begin
                        s_n = s + S_ONE;
                    end
                end
            end
            BREAK: begin
                // wait out a held-low line before hunting for a start bit
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: table of frames plus
// hand-written glitch, break, back-to-back and reset sequences.
module tb_uart_rx_deser;
    import uart_pkg::*;

    localparam int BIT = 64;

    typedef struct {
        logic [7:0] data;
        int         per;
        logic       stopv;
        int         exp_done;
        int         exp_err;
        logic [7:0] exp_dout;
    } vec_t;

    logic       CLK    = 1'b0;
    logic       RESET  = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx     = 1'b1;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    int         err_cnt  = 0;
    logic [7:0] hist[$];
    logic       prev_done = 1'b0;
    logic       prev_err  = 1'b0;
    logic [1:0] tcnt = 2'd0;

    uart_rx_deser dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .s_tick       (s_tick),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        tcnt   <= tcnt + 2'd1;
        s_tick <= (tcnt == 2'd3);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) begin
        #1;
        if (RESET) begin
            if (rx_done_tick || frame_err) begin
                check("pulse_excl", {31'd0, rx_done_tick & frame_err}, 0);
                check("pulse_width",
                      {31'd0, (rx_done_tick & prev_done) |
                              (frame_err & prev_err)}, 0);
            end
            if (rx_done_tick) begin
                done_cnt++;
                hist.push_back(dout);
            end
            if (frame_err) err_cnt++;
        end
        prev_done = rx_done_tick;
        prev_err  = frame_err;
    end

    task automatic wait_clk(input int k);
        repeat (k) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input int per,
                              input logic stopv);
        rx = 1'b0;
        wait_clk(per);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clk(per);
        end
        rx = stopv;
        wait_clk(per);
    endtask

    vec_t vecs[7];
    int   d0, e0;

    initial begin
        vecs[0] = '{8'hC3, 62, 1'b1, 1, 0, 8'hC3};
        vecs[1] = '{8'hC3, 66, 1'b1, 1, 0, 8'hC3};
        vecs[2] = '{8'hA5, 64, 1'b1, 1, 0, 8'hA5};
        vecs[3] = '{8'h01, 64, 1'b1, 1, 0, 8'h01};
        vecs[4] = '{8'h80, 64, 1'b1, 1, 0, 8'h80};
        vecs[5] = '{8'h3C, 64, 1'b0, 0, 1, 8'h80};
        vecs[6] = '{8'h5A, 62, 1'b1, 1, 0, 8'h5A};

        rx    = 1'b1;
        RESET = 1'b0;
        wait_clk(3);
        check("rst_dout", {24'd0, dout}, 0);
        check("rst_done", {31'd0, rx_done_tick}, 0);
        check("rst_err", {31'd0, frame_err}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        RESET = 1'b1;
        wait_clk(10);

        // frame 0x55 with busy window checks
        d0 = done_cnt;
        e0 = err_cnt;
        rx = 1'b0;
        wait_clk(1);
        check("t1_busy_sync", {31'd0, busy}, 0);
        wait_clk(3);
        check("t1_busy_start", {31'd0, busy}, 1);
        wait_clk(BIT - 4);
        for (int i = 0; i < 8; i++) begin
            rx = i[0] ? 1'b0 : 1'b1;
            wait_clk(BIT);
        end
        rx = 1'b1;
        wait_clk(4);
        check("t1_busy_stop", {31'd0, busy}, 1);
        check("t1_no_early", done_cnt - d0, 0);
        wait_clk(BIT - 4 + 2 * BIT);
        check("t1_done", done_cnt - d0, 1);
        check("t1_dout", {24'd0, dout}, 32'h55);
        check("t1_err", err_cnt - e0, 0);
        check("t1_busy_end", {31'd0, busy}, 0);

        // bad stop bit then break, then recovery with 0x81
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'h3C, BIT, 1'b0);
        wait_clk(20 * BIT);
        check("brk_err", err_cnt - e0, 1);
        check("brk_done", done_cnt - d0, 0);
        check("brk_dout", {24'd0, dout}, 32'h55);
        check("brk_busy", {31'd0, busy}, 1);
        rx = 1'b1;
        wait_clk(2 * BIT);
        check("brk_idle", {31'd0, busy}, 0);
        check("brk_err_once", err_cnt - e0, 1);
        send_frame(8'h81, BIT, 1'b1);
        rx = 1'b1;
        wait_clk(2 * BIT);
        check("brk_rec_done", done_cnt - d0, 1);
        check("brk_rec_dout", {24'd0, dout}, 32'h81);

        foreach (vecs[k]) begin
            d0 = done_cnt;
            e0 = err_cnt;
            send_frame(vecs[k].data, vecs[k].per, vecs[k].stopv);
            rx = 1'b1;
            wait_clk(2 * BIT);
            check($sformatf("vec%0d_done", k), done_cnt - d0,
                  vecs[k].exp_done);
            check($sformatf("vec%0d_err", k), err_cnt - e0,
                  vecs[k].exp_err);
            check($sformatf("vec%0d_dout", k), {24'd0, dout},
                  {24'd0, vecs[k].exp_dout});
        end

        // back-to-back frames, no idle gap
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'h00, BIT, 1'b1);
        send_frame(8'hFF, BIT, 1'b1);
        rx = 1'b1;
        wait_clk(2 * BIT);
        check("b2b_done", done_cnt - d0, 2);
        check("b2b_err", err_cnt - e0, 0);
        if (hist.size() >= 2) begin
            check("b2b_first", {24'd0, hist[hist.size()-2]}, 0);
            check("b2b_second", {24'd0, hist[hist.size()-1]}, 32'hFF);
        end else begin
            check("b2b_hist", hist.size(), 2);
        end

        // short glitch: 5 ticks low
        d0 = done_cnt;
        e0 = err_cnt;
        rx = 1'b0;
        wait_clk(20);
        rx = 1'b1;
        check("gl_busy_hi", {31'd0, busy}, 1);
        wait_clk(40);
        check("gl_busy_lo", {31'd0, busy}, 0);
        wait_clk(12 * BIT);
        check("gl_done", done_cnt - d0, 0);
        check("gl_err", err_cnt - e0, 0);

        // async reset during data bit 4 of 0xA5
        rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = (8'hA5 >> i) & 8'h01 ? 1'b1 : 1'b0;
            wait_clk(BIT);
        end
        rx = 1'b0;
        wait_clk(BIT / 2);
        check("rm_busy_pre", {31'd0, busy}, 1);
        RESET = 1'b0;
        #1;
        check("rm_dout", {24'd0, dout}, 0);
        check("rm_done", {31'd0, rx_done_tick}, 0);
        check("rm_err", {31'd0, frame_err}, 0);
        check("rm_busy", {31'd0, busy}, 0);
        rx = 1'b1;
        wait_clk(5);
        RESET = 1'b1;
        d0 = done_cnt;
        e0 = err_cnt;
        wait_clk(2 * BIT);
        check("rm_quiet", done_cnt - d0, 0);
        send_frame(8'h7E, BIT, 1'b1);
        rx = 1'b1;
        wait_clk(2 * BIT);
        check("rm_rec_done", done_cnt - d0, 1);
        check("rm_rec_dout", {24'd0, dout}, 32'h7E);
        check("rm_rec_err", err_cnt - e0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
